// File: rtl/delay_comp_pkg.sv
// Shared definitions for the delay-compensation frame generator: FSM encoding,
// default header tag and frame word width.
package delay_comp_pkg;

  localparam int         WORD_W      = 16;
  localparam logic [7:0] DEF_HDR_TAG = 8'hD5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SLV  = 3'd2,
    LOOP = 3'd3,
    CSUM = 3'd4
  } state_t;

endpackage

// File: rtl/delay_comp_frame_gen_if.sv
// Valid/ready word stream from the frame generator into the master TX frame builder.
interface delay_comp_frame_gen_if;
  import delay_comp_pkg::*;

  logic              TxValid;
  logic [WORD_W-1:0] TxData;
  logic              TxLast;
  logic              TxReady;

  modport master (output TxValid, output TxData, output TxLast, input TxReady);
  modport slave  (input TxValid, input TxData, input TxLast, output TxReady);

endinterface

// File: rtl/delay_comp_accum.sv
// 16-bit accumulator with load and add controls; SAT_EN selects clamping at all-ones
// instead of wrap-around.
module delay_comp_accum
  import delay_comp_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic              Clk_100MHz,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] loadVal,
  input  logic              add,
  input  logic [WORD_W-1:0] addVal,
  output logic [WORD_W-1:0] acc
);

  logic [WORD_W:0] sum;

  assign sum = {1'b0, acc} + {1'b0, addVal};

  always_ff @(posedge Clk_100MHz or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= loadVal;
    end else if (add) begin
      acc <= (SAT_EN && sum[WORD_W]) ? '1 : sum[WORD_W-1:0];
    end
  end

endmodule

// File: rtl/delay_comp_frame_gen.sv
// Builds the delay-compensation frame (header, cumulative slave offsets, loop delay).
// Optional trailing checksum word enabled by defining DELAY_COMP_CSUM_EN.
module delay_comp_frame_gen
  import delay_comp_pkg::*;
#(
  parameter logic [7:0] HDR_TAG    = DEF_HDR_TAG,
  parameter int         MAX_SLAVES = 64
) (
  input  logic                   Clk_100MHz,
  input  logic                   rst,
  input  logic                   MeasDone,
  input  logic [15:0]            RegLoopDelay,
  input  logic [7:0]             AveTransDelay,
  input  logic [7:0]             AveLogicDelay,
  input  logic [7:0]             LastSlaveIDPlus1,
  input  logic                   ClrErr,
  output logic                   Busy,
  output logic                   OverrunErr,
  output logic                   RangeErr,
  delay_comp_frame_gen_if.master tx
);

  localparam logic [7:0] MAX_NC = 8'(MAX_SLAVES);

  state_t            state, stateNxt;
  logic [7:0]        ncSnap, slvCnt;
  logic [15:0]       loopSnap;
  logic [8:0]        stepSnap;
  logic              txValid, txLast;
  logic [WORD_W-1:0] txData, dataNxt, slvAcc;
  logic              accept, snap, loadData, lastNxt, slvAdd, cntInc, rangeHit;
  logic [7:0]        ncIn;

  assign accept   = txValid & tx.TxReady;
  assign rangeHit = LastSlaveIDPlus1 > MAX_NC;
  assign ncIn     = rangeHit ? MAX_NC : LastSlaveIDPlus1;

  // Accumulator holds the offset of the next slave word still to be loaded into txData.
  delay_comp_accum #(.SAT_EN(1'b1)) uSlvAcc (
    .Clk_100MHz (Clk_100MHz),
    .rst        (rst),
    .load       (snap),
    .loadVal    ({8'd0, AveTransDelay}),
    .add        (slvAdd),
    .addVal     ({7'd0, stepSnap}),
    .acc        (slvAcc)
  );

`ifdef DELAY_COMP_CSUM_EN
  logic              csumAdd;
  logic [WORD_W-1:0] csumAcc;

  // Running sum includes each word at the moment it is loaded into txData.
  delay_comp_accum #(.SAT_EN(1'b0)) uCsumAcc (
    .Clk_100MHz (Clk_100MHz),
    .rst        (rst),
    .load       (snap),
    .loadVal    ({HDR_TAG, ncIn}),
    .add        (csumAdd),
    .addVal     (dataNxt),
    .acc        (csumAcc)
  );
`endif

  always_ff @(posedge Clk_100MHz or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    snap     = 1'b0;
    loadData = 1'b0;
    dataNxt  = txData;
    lastNxt  = 1'b0;
    slvAdd   = 1'b0;
    cntInc   = 1'b0;
`ifdef DELAY_COMP_CSUM_EN
    csumAdd  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (MeasDone) begin
          snap = 1'b1;
          if (ncIn != 8'd0) begin
            stateNxt = HDR;
            loadData = 1'b1;
            dataNxt  = {HDR_TAG, ncIn};
          end
        end
      end
      HDR: begin
        if (accept) begin
          stateNxt = SLV;
          loadData = 1'b1;
          dataNxt  = slvAcc;
          slvAdd   = 1'b1;
`ifdef DELAY_COMP_CSUM_EN
          csumAdd  = 1'b1;
`endif
        end
      end
      SLV: begin
        if (accept) begin
          loadData = 1'b1;
`ifdef DELAY_COMP_CSUM_EN
          csumAdd  = 1'b1;
`endif
          if (slvCnt == ncSnap - 8'd1) begin
            stateNxt = LOOP;
            dataNxt  = loopSnap;
`ifdef DELAY_COMP_CSUM_EN
            lastNxt  = 1'b0;
`else
            lastNxt  = 1'b1;
`endif
          end else begin
            dataNxt = slvAcc;
            slvAdd  = 1'b1;
            cntInc  = 1'b1;
          end
        end
      end
      LOOP: begin
        if (accept) begin
`ifdef DELAY_COMP_CSUM_EN
          stateNxt = CSUM;
          loadData = 1'b1;
          dataNxt  = csumAcc;
          lastNxt  = 1'b1;
`else
          stateNxt = IDLE;
`endif
        end
      end
`ifdef DELAY_COMP_CSUM_EN
      CSUM: begin
        if (accept) begin
          stateNxt = IDLE;
        end
      end
`endif
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_100MHz or posedge rst) begin
    if (rst) begin
      txValid    <= 1'b0;
      txData     <= '0;
      txLast     <= 1'b0;
      Busy       <= 1'b0;
      ncSnap     <= '0;
      loopSnap   <= '0;
      stepSnap   <= '0;
      slvCnt     <= '0;
      OverrunErr <= 1'b0;
      RangeErr   <= 1'b0;
    end else begin
      txValid <= (stateNxt != IDLE);
      Busy    <= (stateNxt != IDLE);
      if (loadData) begin
        txData <= dataNxt;
        txLast <= lastNxt;
      end else if (stateNxt == IDLE) begin
        txLast <= 1'b0;
      end
      if (snap) begin
        ncSnap   <= ncIn;
        loopSnap <= RegLoopDelay;
        stepSnap <= {1'b0, AveTransDelay} + {1'b0, AveLogicDelay};
        slvCnt   <= '0;
      end else if (cntInc) begin
        slvCnt <= slvCnt + 8'd1;
      end
      // Error flags: a new event in the same cycle as ClrErr keeps the flag set.
      if (MeasDone && state != IDLE) begin
        OverrunErr <= 1'b1;
      end else if (ClrErr) begin
        OverrunErr <= 1'b0;
      end
      if (snap && rangeHit) begin
        RangeErr <= 1'b1;
      end else if (ClrErr) begin
        RangeErr <= 1'b0;
      end
    end
  end

  assign tx.TxValid = txValid;
  assign tx.TxData  = txData;
  assign tx.TxLast  = txLast;

endmodule

// File: tb/tb_delay_comp_frame_gen.sv
// Scoreboard bench: expected frame words are queued when a measurement is issued and
// compared on every cycle the DUT presents a valid word.
module tb_delay_comp_frame_gen;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        measA = 1'b0, measB = 1'b0, clrErr = 1'b0;
  logic [15:0] loopDly = '0;
  logic [7:0]  tIn = '0, lIn = '0, nIn = '0;
  logic        readyA, readyB = 1'b1;
  logic        busyA, ovrA, rngA, busyB, ovrB, rngB;
  bit          rdyMode = 1'b0;
  bit [3:0]    pat = 4'b1001;
  int          ph = 0;
  int          nCmp = 0, nErr = 0;
  word_t       qA[$], qB[$];

  delay_comp_frame_gen_if ifA ();
  delay_comp_frame_gen_if ifB ();

  assign ifA.TxReady = readyA;
  assign ifB.TxReady = readyB;

  delay_comp_frame_gen dutA (
    .Clk_100MHz(clk), .rst(rst), .MeasDone(measA), .RegLoopDelay(loopDly),
    .AveTransDelay(tIn), .AveLogicDelay(lIn), .LastSlaveIDPlus1(nIn), .ClrErr(clrErr),
    .Busy(busyA), .OverrunErr(ovrA), .RangeErr(rngA), .tx(ifA)
  );

  delay_comp_frame_gen #(.MAX_SLAVES(255)) dutB (
    .Clk_100MHz(clk), .rst(rst), .MeasDone(measB), .RegLoopDelay(loopDly),
    .AveTransDelay(tIn), .AveLogicDelay(lIn), .LastSlaveIDPlus1(nIn), .ClrErr(clrErr),
    .Busy(busyB), .OverrunErr(ovrB), .RangeErr(rngB), .tx(ifB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference frame: offsets computed in closed form, then clipped to 16'hFFFF.
  task automatic pushFrame(input bit toB, input int t, input int l, input int n,
                           input int loop, input int maxs);
    int    nc, sum, v;
    word_t w;
    nc = (n > maxs) ? maxs : n;
    if (nc == 0) return;
    w.d = {8'hD5, 8'(nc)}; w.last = 1'b0; sum = int'(w.d);
    if (toB) qB.push_back(w); else qA.push_back(w);
    for (int k = 0; k < nc; k++) begin
      v = (k + 1) * t + k * l;
      w.d = (v > 65535) ? 16'hFFFF : 16'(v);
      sum += int'(w.d);
      if (toB) qB.push_back(w); else qA.push_back(w);
    end
    w.d = 16'(loop); sum += loop;
`ifdef DELAY_COMP_CSUM_EN
    w.last = 1'b0;
    if (toB) qB.push_back(w); else qA.push_back(w);
    w.d = 16'(sum); w.last = 1'b1;
`else
    w.last = 1'b1;
`endif
    if (toB) qB.push_back(w); else qA.push_back(w);
  endtask

  task automatic meas(input bit toB, input logic [7:0] t, input logic [7:0] l,
                      input logic [7:0] n, input logic [15:0] loop);
    @(posedge clk); #1;
    tIn = t; lIn = l; nIn = n; loopDly = loop;
    if (toB) measB = 1'b1; else measA = 1'b1;
    @(posedge clk); #1;
    measA = 1'b0; measB = 1'b0;
  endtask

  task automatic waitDone(input bit toB, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!toB && !busyA && qA.size() == 0) begin ok = 1'b1; break; end
      if (toB && !busyB && qB.size() == 0) begin ok = 1'b1; break; end
    end
    chk({tag, "_drained"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    readyA = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdyMode) begin
        readyA = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        readyA = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    word_t e;
    if (!rst && ifA.TxValid) begin
      if (qA.size() == 0) chk("A_spurious_valid", {31'd0, ifA.TxValid}, 32'd0);
      else begin
        chk("A_data", {16'd0, ifA.TxData}, {16'd0, qA[0].d});
        chk("A_last", {31'd0, ifA.TxLast}, {31'd0, qA[0].last});
        if (ifA.TxReady) e = qA.pop_front();
      end
    end
    if (!rst && ifB.TxValid) begin
      if (qB.size() == 0) chk("B_spurious_valid", {31'd0, ifB.TxValid}, 32'd0);
      else begin
        chk("B_data", {16'd0, ifB.TxData}, {16'd0, qB[0].d});
        chk("B_last", {31'd0, ifB.TxLast}, {31'd0, qB[0].last});
        if (ifB.TxReady) e = qB.pop_front();
      end
    end
  end

  initial begin
    #22;
    chk("rst_valid", {31'd0, ifA.TxValid}, 32'd0);
    chk("rst_data", {16'd0, ifA.TxData}, 32'd0);
    chk("rst_last", {31'd0, ifA.TxLast}, 32'd0);
    chk("rst_busy", {31'd0, busyA}, 32'd0);
    chk("rst_err", {30'd0, ovrA, rngA}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic frame, one-cycle latency from MeasDone
    pushFrame(0, 10, 4, 3, 16'h0100, 64);
    meas(0, 8'd10, 8'd4, 8'd3, 16'h0100);
    chk("t1_latency_valid", {31'd0, ifA.TxValid}, 32'd1);
    chk("t1_busy", {31'd0, busyA}, 32'd1);
    waitDone(0, "t1");

    // Back-pressure pattern
    rdyMode = 1'b1;
    pushFrame(0, 10, 4, 3, 16'h0100, 64);
    meas(0, 8'd10, 8'd4, 8'd3, 16'h0100);
    waitDone(0, "t2");
    rdyMode = 1'b0;

    // Empty frame, then clipped slave count
    meas(0, 8'd7, 8'd3, 8'd0, 16'h0042);
    for (int i = 0; i < 4; i++) begin
      chk("t3_n0_busy", {31'd0, busyA}, 32'd0);
      @(posedge clk); #1;
    end
    pushFrame(0, 3, 2, 70, 16'h0ABC, 64);
    meas(0, 8'd3, 8'd2, 8'd70, 16'h0ABC);
    chk("t3_range_err", {31'd0, rngA}, 32'd1);
    waitDone(0, "t3");
    @(posedge clk); #1 clrErr = 1'b1;
    @(posedge clk); #1 clrErr = 1'b0;
    chk("t3_range_clr", {31'd0, rngA}, 32'd0);

    // Saturation on the wide-count instance
    pushFrame(1, 255, 255, 200, 16'h1234, 255);
    meas(1, 8'd255, 8'd255, 8'd200, 16'h1234);
    chk("t4_range_err", {31'd0, rngB}, 32'd0);
    waitDone(1, "t4");

    // Overrun with simultaneous clear, then later clear
    pushFrame(0, 20, 5, 4, 16'h0200, 64);
    meas(0, 8'd20, 8'd5, 8'd4, 16'h0200);
    @(posedge clk); #1;
    measA = 1'b1; clrErr = 1'b1; tIn = 8'd99; lIn = 8'd1; nIn = 8'd9; loopDly = 16'hBEEF;
    @(posedge clk); #1;
    measA = 1'b0; clrErr = 1'b0;
    chk("t5_overrun_set", {31'd0, ovrA}, 32'd1);
    waitDone(0, "t5");
    chk("t5_overrun_hold", {31'd0, ovrA}, 32'd1);
    @(posedge clk); #1 clrErr = 1'b1;
    @(posedge clk); #1 clrErr = 1'b0;
    chk("t5_overrun_clr", {31'd0, ovrA}, 32'd0);

    // Async reset mid-frame, then a fresh frame
    pushFrame(0, 6, 2, 10, 16'h0333, 64);
    meas(0, 8'd6, 8'd2, 8'd10, 16'h0333);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", {31'd0, ifA.TxValid}, 32'd0);
    chk("t6_async_busy", {31'd0, busyA}, 32'd0);
    qA.delete();
    @(posedge clk); #1 rst = 1'b0;
    pushFrame(0, 9, 1, 2, 16'h0777, 64);
    meas(0, 8'd9, 8'd1, 8'd2, 16'h0777);
    chk("t6_restart_valid", {31'd0, ifA.TxValid}, 32'd1);
    waitDone(0, "t6");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
